// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side binary/Gray pointers, RAM write address and registered full flag.
// Optional almost_full output and its occupancy logic are built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_full #(
    parameter int PTR_WIDTH = 4,
    parameter int AF_THRESH = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   rptr_gray_sync,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_bin,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic                 w_accept,
    output logic                 full,
`ifdef FIFO_ALMOST_FULL_EN
    output logic                 almost_full,
`endif
    output logic                 overflow_err
);
    logic [PTR_WIDTH:0] wbin_next;
    logic [PTR_WIDTH:0] wgray_next;
    logic               full_next;

    assign waddr      = wptr_bin[PTR_WIDTH-1:0];
    assign w_accept   = w_en & ~full;
    assign wbin_next  = wptr_bin + {{PTR_WIDTH{1'b0}}, w_accept};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_next  = wgray_next == {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_sync[PTR_WIDTH-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_bin     <= '0;
            wptr_gray    <= '0;
            full         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            wptr_bin     <= wbin_next;
            wptr_gray    <= wgray_next;
            full         <= full_next;
            overflow_err <= overflow_err | (w_en & full);
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    logic [PTR_WIDTH:0] rbin_sync;
    logic [PTR_WIDTH:0] level;

    for (genvar i = 0; i <= PTR_WIDTH; i++) begin : g_g2b
        assign rbin_sync[i] = ^rptr_gray_sync[PTR_WIDTH:i];
    end

    assign level = wbin_next - rbin_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full <= 1'b0;
        else     almost_full <= int'(level) >= AF_THRESH;
    end
`endif
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized and directed checks of fifo_wptr_full against an occupancy-count model.
module tb_fifo_wptr_full;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_en = 1'b0;
    logic [4:0] rptr_gray_sync = '0;
    logic [3:0] waddr;
    logic [4:0] wptr_bin;
    logic [4:0] wptr_gray;
    logic       w_accept;
    logic       full;
    logic       overflow_err;
`ifdef FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int  nchk = 0;
    int  nfail = 0;
    int  wc, rc;
    bit  mfull, movf, maf;

    always #5 clk = ~clk;

    fifo_wptr_full #(.PTR_WIDTH(4), .AF_THRESH(14)) dut (
        .clk(clk),
        .rst(rst),
        .w_en(w_en),
        .rptr_gray_sync(rptr_gray_sync),
        .waddr(waddr),
        .wptr_bin(wptr_bin),
        .wptr_gray(wptr_gray),
        .w_accept(w_accept),
        .full(full),
`ifdef FIFO_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .overflow_err(overflow_err)
    );

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wc = 0; rc = 0; mfull = 0; movf = 0; maf = 0;
    endtask

    task automatic check_regs();
        chk("wptr_bin", int'(wptr_bin), wc);
        chk("wptr_gray", int'(wptr_gray), gray(wc));
        chk("waddr", int'(waddr), wc % 16);
        chk("full", int'(full), int'(mfull));
        chk("overflow_err", int'(overflow_err), int'(movf));
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", int'(almost_full), int'(maf));
`endif
    endtask

    // One write-clock cycle: r is the reader's synchronized count (occupancy = wc - r mod 32).
    task automatic step(input bit w, input int r);
        bit acc;
        int occ;
        @(negedge clk);
        w_en = w;
        rc = r % 32;
        rptr_gray_sync = 5'(gray(rc));
        #1;
        acc = w && !mfull;
        chk("w_accept", int'(w_accept), int'(acc));
        if (w && mfull) movf = 1;
        wc = (wc + int'(acc)) % 32;
        occ = (wc - rc + 32) % 32;
        mfull = occ == 16;
        maf = occ >= 14;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic hw_reset();
        @(negedge clk);
        w_en = 1'b0;
        rptr_gray_sync = '0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_regs();

        for (int i = 0; i < 16; i++) step(1'b1, 0);
        chk("fill_bin", int'(wptr_bin), 'h10);
        chk("fill_gray", int'(wptr_gray), 'h18);
        chk("fill_full", int'(full), 1);

        for (int i = 0; i < 3; i++) step(1'b1, 0);
        chk("ovf_bin", int'(wptr_bin), 'h10);
        chk("ovf_flag", int'(overflow_err), 1);

        step(1'b0, 1);
        chk("read_unfull", int'(full), 0);
        step(1'b1, 1);
        chk("refill_bin", int'(wptr_bin), 'h11);
        chk("refill_full", int'(full), 1);

        hw_reset();
        for (int i = 0; i < 400; i++) begin
            int occ, r;
            occ = (wc - rc + 32) % 32;
            r = (occ > 0 && $urandom_range(0, 1) == 1) ? rc + 1 : rc;
            step($urandom_range(0, 3) != 0, r);
        end

        hw_reset();
        for (int i = 0; i < 31; i++) step(1'b1, wc);
        chk("prewrap_gray", int'(wptr_gray), 'h10);
        step(1'b1, wc);
        chk("wrap_bin", int'(wptr_bin), 0);
        chk("wrap_gray", int'(wptr_gray), 0);
        chk("wrap_full", int'(full), 0);

        hw_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 0);
        chk("burst_bin", int'(wptr_bin), 'h07);
        @(negedge clk);
        w_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_bin", int'(wptr_bin), 0);
        chk("arst_gray", int'(wptr_gray), 0);
        chk("arst_waddr", int'(waddr), 0);
        chk("arst_full", int'(full), 0);
        chk("arst_ovf", int'(overflow_err), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 0);
        chk("resume_bin", int'(wptr_bin), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
